// File: rtl/cam_alloc_ctrl.sv
// cam_alloc_ctrl: lookup-or-allocate front end for a SIZE-entry CAM.
// Round-robin victim allocation, hit/evict response, saturating stats.
module cam_alloc_ctrl #(
  parameter  int SIZE = 8,
  localparam int IW   = $clog2(SIZE)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [IW-1:0] rsp_idx,
  output logic          rsp_hit,
  output logic          rsp_evict,
  output logic          cam_enable,
  output logic          cam_command,
  output logic [31:0]   cam_data,
  output logic [IW-1:0] cam_write_idx,
  input  logic [IW-1:0] cam_read_idx,
  input  logic          cam_hit,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
);

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] CHECK  = 3'd2;
  localparam logic [2:0] ALLOC  = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [31:0]     key_q, key_d;
  logic [IW-1:0]   victim_q, victim_d;
  logic [SIZE-1:0] bitmap_q, bitmap_d;
  logic [IW-1:0]   rsp_idx_q, rsp_idx_d;
  logic            rsp_hit_q, rsp_hit_d;
  logic            rsp_evict_q, rsp_evict_d;
  logic [15:0]     hit_count_q, hit_count_d;
  logic [15:0]     miss_count_q, miss_count_d;

  // Next-state and datapath updates for one request at a time
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    victim_d     = victim_q;
    bitmap_d     = bitmap_q;
    rsp_idx_d    = rsp_idx_q;
    rsp_hit_d    = rsp_hit_q;
    rsp_evict_d  = rsp_evict_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          key_d   = req_data;
          state_d = LOOKUP;
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK: begin
        if (cam_hit) begin
          rsp_idx_d   = cam_read_idx;
          rsp_hit_d   = 1'b1;
          rsp_evict_d = 1'b0;
          if (hit_count_q != 16'hFFFF)
            hit_count_d = hit_count_q + 16'd1;
          state_d = RESP;
        end else begin
          if (miss_count_q != 16'hFFFF)
            miss_count_d = miss_count_q + 16'd1;
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        rsp_idx_d          = victim_q;
        rsp_hit_d          = 1'b0;
        rsp_evict_d        = bitmap_q[victim_q];
        bitmap_d[victim_q] = 1'b1;
        victim_d           = victim_q + IW'(1);
        state_d            = RESP;
      end
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      key_q        <= '0;
      victim_q     <= '0;
      bitmap_q     <= '0;
      rsp_idx_q    <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_evict_q  <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      victim_q     <= victim_d;
      bitmap_q     <= bitmap_d;
      rsp_idx_q    <= rsp_idx_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_evict_q  <= rsp_evict_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Handshake and CAM drive decoded straight from the state register
  always_comb begin
    req_ready     = (state_q == IDLE);
    rsp_valid     = (state_q == RESP);
    cam_enable    = (state_q == LOOKUP) || (state_q == ALLOC);
    cam_command   = (state_q == ALLOC) ? CMD_WRITE : CMD_READ;
    cam_data      = key_q;
    cam_write_idx = victim_q;
    rsp_idx       = rsp_idx_q;
    rsp_hit       = rsp_hit_q;
    rsp_evict     = rsp_evict_q;
    hit_count     = hit_count_q;
    miss_count    = miss_count_q;
  end

endmodule
